uart_tx_device: RTL and testbench
=================================

# uart_tx_device

Memory-mapped UART transmitter that responds on the single-cycle CPU's data-memory bus, next to `Device`. Byte writes from the CPU go into a small TX FIFO. A baud-rate state machine then serializes them as 8N1 frames on `uart_tx`. Status and baud-divider registers are readable over the same bus. With this block, programs running on `CPU` can emit serial output without stalling.

## Interface
- `BASE_ADDR`, default 32'h4000_0020: word-aligned base of the 4-word register window.
- `FIFO_DEPTH`, default 4: TX FIFO entries; must be a power of 2, at least 2.
- `DEFAULT_DIV`, default 16'd868: reset value of BAUDDIV, in clk cycles per bit.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `MemBus_Address`, input, 32: byte address from CPU; bits [1:0] ignored.
- `MemBus_Write_Data`, input, 32: write data from CPU.
- `MemRead`, input, 1: read strobe, combinational, same cycle as address.
- `MemWrite`, input, 1: write strobe; the write commits at the rising edge.
- `Device_Read_Data`, output, 32: combinational read data; 0 when not selected.
- `uart_tx`, output, 1: registered serial line; idle high.
- `tx_irq`, output, 1: present only with `UART_TX_IRQ_EN`.

## Operation
- Select when `MemBus_Address[31:4] == BASE_ADDR[31:4]`. Register offset is `MemBus_Address[3:2]`.
- Offset 0, TXDATA, write-only: pushes `MemBus_Write_Data[7:0]`. If the FIFO is full and no pop happens the same cycle, the byte is dropped and OVERFLOW is set. Reads return 0.
- Offset 1, STATUS: read-only except bit 3.
  - bit0 BUSY: FSM is not in IDLE.
  - bit1 FULL.
  - bit2 EMPTY.
  - bit3 OVERFLOW: sticky; a write with bit3=1 clears it.
  - bits[7:4] COUNT: FIFO occupancy.
  - All other bits read 0.
- Offset 2, BAUDDIV, R/W, bits [15:0]: writing 0 stores 1. A new value takes effect at the next bit boundary; the bit in progress keeps the old divider.
- Offset 3: reserved, reads 0 (IRQ_EN when `UART_TX_IRQ_EN` is defined).
- `Device_Read_Data = (MemRead && selected) ? reg : 32'h0`.
- FSM states:
  - IDLE: uart_tx=1. If the FIFO is not empty, pop the head into the shift register and go to START.
  - START: uart_tx=0 for BAUDDIV cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held for BAUDDIV cycles, then go to STOP.
  - STOP: uart_tx=1 for BAUDDIV cycles. Then pop and go to START if the FIFO is not empty (no idle gap), else go to IDLE.
- Bit counter is 3 bits. Baud counter counts down from BAUDDIV-1 to 0 and is reloaded at each bit boundary.
- A push and a pop in the same cycle leave COUNT unchanged. FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values:
  - uart_tx=1, FSM=IDLE, FIFO empty (COUNT=0, EMPTY=1).
  - OVERFLOW=0, BAUDDIV=DEFAULT_DIV.
  - tx_irq=0, IRQ_EN=0.
  - Device_Read_Data follows the combinational rule above.
- A write to TXDATA at edge N makes the FIFO non-empty after edge N. The FSM pops at edge N+1, and uart_tx falls after edge N+1.
- A frame is exactly 10×BAUDDIV cycles. Back-to-back frames have zero idle cycles.
- Reads are combinational. A STATUS read reflects the state after the previous edge.
- Reset asserted mid-frame: after that edge uart_tx=1 and all FIFO contents are discarded.

## Configuration
- `UART_TX_IRQ_EN` defined:
  - Adds the `tx_irq` port and IRQ_EN at offset 3, bit0 R/W.
  - `tx_irq` is registered: `tx_irq <= IRQ_EN & EMPTY & ~BUSY`.
  - Writing IRQ_EN=0 drops tx_irq on the next edge.
- `UART_TX_IRQ_EN` undefined: no `tx_irq` port; offset 3 reads 0 and writes to it are ignored.

## Test plan
- Reset, then read STATUS: 32'h0000_0004. Read BAUDDIV: 868. uart_tx=1.
- BAUDDIV=4, write 0xA5: uart_tx falls one edge after the write. Bits sampled every 4 cycles are 0,1,0,1,0,0,1,0,1,1. The frame is 40 cycles, then BUSY=0.
- BAUDDIV=2, five TXDATA writes in consecutive cycles (0x01–0x05):
  - First byte is popped at the edge after the first write (COUNT 1→0).
  - Remaining four fill the FIFO: FULL=1, COUNT=4, OVERFLOW=0.
  - A sixth write while full sets OVERFLOW=1 and drops the byte.
  - Five frames are emitted back-to-back in 100 cycles, with no gap.
- Write 0x08 to STATUS: OVERFLOW clears. Read an unmapped address with MemRead=1: Device_Read_Data=0.
- Assert reset mid-DATA with 3 bytes queued: next cycle uart_tx=1, COUNT=0, BAUDDIV=868, and no further frames.
- With `UART_TX_IRQ_EN`, IRQ_EN=1, one byte sent at BAUDDIV=4: tx_irq=0 while busy and rises one edge after STOP completes.

Source files
------------

// File: rtl/uart_tx_device.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and a programmable baud divider.
// Optional build macro UART_TX_IRQ_EN adds IRQ_EN at offset 3 and the tx_irq output.
module uart_tx_device #(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0020,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MemBus_Address,
    input  logic [31:0] MemBus_Write_Data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Device_Read_Data,
    output logic        uart_tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        tx_irq
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [15:0]    baud_cnt_r;
    logic [15:0]    baud_cnt_nxt_s;
    logic [2:0]     bit_cnt_r;
    logic [2:0]     bit_cnt_nxt_s;
    logic [7:0]     shift_r;
    logic [7:0]     shift_nxt_s;
    logic           tx_r;
    logic           tx_nxt_s;

    logic [7:0]     fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           overflow_r;
    logic [15:0]    baud_div_r;

    logic           sel_s;
    logic [1:0]     off_s;
    logic           wr_txdata_s;
    logic           wr_status_s;
    logic           wr_div_s;
    logic           full_s;
    logic           empty_s;
    logic           busy_s;
    logic           push_s;
    logic           pop_s;
    logic           ovf_set_s;
    logic [7:0]     head_s;
    logic [15:0]    reload_s;
    logic           baud_zero_s;
    logic [3:0]     count4_s;
    logic [31:0]    status_s;
    logic [31:0]    rd_reg_s;
    logic           unused_bits_s;

    assign sel_s       = (MemBus_Address[31:4] == BASE_ADDR[31:4]);
    assign off_s       = MemBus_Address[3:2];
    assign wr_txdata_s = sel_s & MemWrite & (off_s == 2'd0);
    assign wr_status_s = sel_s & MemWrite & (off_s == 2'd1);
    assign wr_div_s    = sel_s & MemWrite & (off_s == 2'd2);

    assign full_s      = (count_r == CW'(FIFO_DEPTH));
    assign empty_s     = (count_r == {CW{1'b0}});
    assign busy_s      = (state_r != ST_IDLE);
    assign head_s      = fifo_mem_r[rd_ptr_r];
    // A push into a full FIFO is still accepted when the FSM pops in the same cycle.
    assign push_s      = wr_txdata_s & (~full_s | pop_s);
    assign ovf_set_s   = wr_txdata_s & full_s & ~pop_s;

    assign reload_s    = baud_div_r - 16'd1;
    assign baud_zero_s = (baud_cnt_r == 16'd0);
    assign count4_s    = 4'(count_r);
    assign status_s    = {24'h00_0000, count4_s, overflow_r, empty_s, full_s, busy_s};
    assign uart_tx     = tx_r;
    assign unused_bits_s = ^{MemBus_Address[1:0], MemBus_Write_Data[31:16]};

    // FIFO storage; pointer reset alone discards contents.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= MemBus_Write_Data[7:0];
        end
    end

    // FIFO pointers, occupancy, sticky overflow and baud divider register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
            baud_div_r <= DEFAULT_DIV;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (wr_status_s && MemBus_Write_Data[3]) begin
                overflow_r <= 1'b0;
            end
            if (wr_div_s) begin
                baud_div_r <= (MemBus_Write_Data[15:0] == 16'd0) ? 16'd1 : MemBus_Write_Data[15:0];
            end
        end
    end

    // Serializer state register; the line output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= 16'd0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            baud_cnt_r <= baud_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            tx_r       <= tx_nxt_s;
        end
    end

    // Next-state logic: every bit lasts baud_div cycles; STOP chains straight into START.
    always_comb begin
        state_nxt_s    = state_r;
        baud_cnt_nxt_s = baud_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        tx_nxt_s       = tx_r;
        pop_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s          = 1'b1;
                    shift_nxt_s    = head_s;
                    baud_cnt_nxt_s = reload_s;
                    state_nxt_s    = ST_START;
                    tx_nxt_s       = 1'b0;
                end else begin
                    tx_nxt_s       = 1'b1;
                end
            end
            ST_START: begin
                if (baud_zero_s) begin
                    baud_cnt_nxt_s = reload_s;
                    bit_cnt_nxt_s  = 3'd0;
                    state_nxt_s    = ST_DATA;
                    tx_nxt_s       = shift_r[0];
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r - 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_zero_s) begin
                    baud_cnt_nxt_s = reload_s;
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s   = ST_STOP;
                        tx_nxt_s      = 1'b1;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                        shift_nxt_s   = {1'b0, shift_r[7:1]};
                        tx_nxt_s      = shift_r[1];
                    end
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r - 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_zero_s) begin
                    if (!empty_s) begin
                        pop_s          = 1'b1;
                        shift_nxt_s    = head_s;
                        baud_cnt_nxt_s = reload_s;
                        state_nxt_s    = ST_START;
                        tx_nxt_s       = 1'b0;
                    end else begin
                        state_nxt_s    = ST_IDLE;
                        tx_nxt_s       = 1'b1;
                    end
                end else begin
                    baud_cnt_nxt_s = baud_cnt_r - 16'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                tx_nxt_s    = 1'b1;
            end
        endcase
    end

`ifdef UART_TX_IRQ_EN
    logic irq_en_r;
    logic wr_irq_s;

    assign wr_irq_s = sel_s & MemWrite & (off_s == 2'd3);

    // Interrupt enable register and registered "transmitter drained" interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_r <= 1'b0;
            tx_irq   <= 1'b0;
        end else begin
            if (wr_irq_s) begin
                irq_en_r <= MemBus_Write_Data[0];
            end
            tx_irq <= irq_en_r & empty_s & ~busy_s;
        end
    end
`endif

    // Register read mux.
    always_comb begin
        rd_reg_s = 32'h0000_0000;
        case (off_s)
            2'd1: rd_reg_s = status_s;
            2'd2: rd_reg_s = {16'h0000, baud_div_r};
`ifdef UART_TX_IRQ_EN
            2'd3: rd_reg_s = {31'h0000_0000, irq_en_r};
`else
            2'd3: rd_reg_s = 32'h0000_0000;
`endif
            default: rd_reg_s = 32'h0000_0000;
        endcase
    end

    assign Device_Read_Data = (MemRead && sel_s) ? rd_reg_s : 32'h0000_0000;

endmodule

// File: tb/tb_uart_tx_device.sv
// Scoreboard bench for uart_tx_device: stimulus queues expected reads and frames,
// independent monitors decode the bus and the serial line and compare.
module tb_uart_tx_device;

    localparam logic [31:0] A_TX  = 32'h4000_0020;
    localparam logic [31:0] A_ST  = 32'h4000_0024;
    localparam logic [31:0] A_DIV = 32'h4000_0028;
    localparam logic [31:0] A_IRQ = 32'h4000_002C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] rdata;
    logic        uart_tx;
`ifdef UART_TX_IRQ_EN
    logic        tx_irq;
`endif

    uart_tx_device dut (
        .clk               (clk),
        .reset             (reset),
        .MemBus_Address    (addr),
        .MemBus_Write_Data (wdata),
        .MemRead           (mem_read),
        .MemWrite          (mem_write),
        .Device_Read_Data  (rdata),
        .uart_tx           (uart_tx)
`ifdef UART_TX_IRQ_EN
        ,
        .tx_irq            (tx_irq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_div = 868;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    typedef struct {
        logic [31:0] data;
        bit          cl;
        logic        ln;
        bit          ci;
        logic        iv;
    } rd_t;

    frame_t frame_q[$];
    rd_t    rd_q[$];
    string  nm_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- stimulus helpers (called just after a rising edge) ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; mem_write = 1'b1;
        @(posedge clk); #1;
        mem_write = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm,
                      input bit cl = 1'b0, input logic ln = 1'b1,
                      input bit ci = 1'b0, input logic iv = 1'b0);
        rd_t e;
        e.data = exp; e.cl = cl; e.ln = ln; e.ci = ci; e.iv = iv;
        rd_q.push_back(e);
        nm_q.push_back(nm);
        addr = a; mem_read = 1'b1;
        @(posedge clk); #1;
        mem_read = 1'b0; addr = 32'h0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic exp_frame(input logic [7:0] d, input int start);
        frame_t f;
        f.data = d; f.start = start;
        frame_q.push_back(f);
    endtask

    // ---------------- bus read monitor ----------------
    initial begin
        rd_t   e;
        string nm;
        forever begin
            @(negedge clk);
            if (mem_read) begin
                chk("read_expected", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) begin
                    e  = rd_q.pop_front();
                    nm = nm_q.pop_front();
                    chk(nm, rdata, e.data);
                    if (e.cl) chk({nm, "_line"}, 32'(uart_tx), 32'(e.ln));
`ifdef UART_TX_IRQ_EN
                    if (e.ci) chk({nm, "_irq"}, 32'(tx_irq), 32'(e.iv));
`endif
                end
            end
        end
    end

    // ---------------- serial line monitor ----------------
    int         m_s = 0;
    int         m_idx = 0;
    bit         m_act = 1'b0;
    logic [9:0] m_bits = 10'h0;

    initial begin
        frame_t f;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_act = 1'b0;
            end else begin
                if (!m_act && uart_tx === 1'b0) begin
                    m_act = 1'b1; m_s = cyc; m_idx = 0;
                    chk("frame_expected", 32'(frame_q.size() != 0), 32'd1);
                end
                if (m_act && cyc == m_s + m_idx * cur_div + cur_div / 2) begin
                    m_bits[m_idx] = uart_tx;
                    m_idx++;
                    if (m_idx == 10) begin
                        m_act = 1'b0;
                        if (frame_q.size() != 0) begin
                            f = frame_q.pop_front();
                            chk("frame_start_cycle", 32'(m_s), 32'(f.start));
                            chk("frame_start_bit", 32'(m_bits[0]), 32'd0);
                            chk("frame_data", 32'(m_bits[8:1]), 32'(f.data));
                            chk("frame_stop_bit", 32'(m_bits[9]), 32'd1);
                        end
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int e;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        rd(A_ST, 32'h4, "reset_status", 1'b1, 1'b1);
        rd(A_DIV, 32'd868, "reset_div");
        rd(A_TX, 32'h0, "txdata_reads_zero");
        rd(A_IRQ, 32'h0, "off3_reset");
        rd(32'h4000_0030, 32'h0, "unmapped_next_window");
`ifdef UART_TX_IRQ_EN
        rd(A_ST, 32'h4, "irq_reset", 1'b0, 1'b1, 1'b1, 1'b0);
`endif

        // single 0xA5 frame at divider 4
        wr(A_DIV, 32'd4); cur_div = 4;
        rd(A_DIV, 32'd4, "div_4");
        wr(A_TX, 32'hA5); e = cyc;
        exp_frame(8'hA5, e + 1);
        rd(A_ST, 32'h10, "status_queued", 1'b1, 1'b1);
        rd(A_ST, 32'h05, "status_busy", 1'b1, 1'b0);
        wait_cyc(e + 40);
        rd(A_ST, 32'h05, "status_last_stop_cycle");
        rd(A_ST, 32'h04, "status_frame_done", 1'b1, 1'b1);

        // divider 0 stores 1
        wr(A_DIV, 32'd0);
        rd(A_DIV, 32'd1, "div_zero_stores_one");

        // burst at divider 2 with overflow
        wr(A_DIV, 32'd2); cur_div = 2;
        wr(A_TX, 32'h01); e = cyc;
        for (int k = 0; k < 5; k++) exp_frame(8'(k + 1), e + 1 + 20 * k);
        wr(A_TX, 32'h02);
        wr(A_TX, 32'h03);
        wr(A_TX, 32'h04);
        wr(A_TX, 32'h05);
        rd(A_ST, 32'h43, "status_full");
        wr(A_TX, 32'h06);
        rd(A_ST, 32'h4B, "status_overflow_set");
        wr(A_ST, 32'h08);
        rd(A_ST, 32'h43, "status_overflow_clear");
        wait_cyc(e + 101);
        rd(A_ST, 32'h04, "status_burst_done", 1'b1, 1'b1);
        rd(32'h0000_0000, 32'h0, "unmapped_low");

        // reset in the middle of a data bit with three bytes queued
        wr(A_DIV, 32'd4); cur_div = 4;
        wr(A_TX, 32'h11); e = cyc;
        exp_frame(8'h11, e + 1);
        wr(A_TX, 32'h22);
        wr(A_TX, 32'h33);
        wr(A_TX, 32'h44);
        wait_cyc(e + 12);
        rd(A_ST, 32'h31, "status_pre_reset");
        reset = 1'b1;
        frame_q.delete();
        @(posedge clk); #1;
        reset = 1'b0; cur_div = 868;
        rd(A_ST, 32'h04, "status_post_reset", 1'b1, 1'b1);
        rd(A_DIV, 32'd868, "div_post_reset");
        repeat (200) begin @(posedge clk); #1; end
        rd(A_ST, 32'h04, "status_quiet_after_reset", 1'b1, 1'b1);

`ifdef UART_TX_IRQ_EN
        wr(A_DIV, 32'd4); cur_div = 4;
        wr(A_IRQ, 32'h1);
        rd(A_IRQ, 32'h1, "irq_en_set", 1'b0, 1'b1, 1'b1, 1'b0);
        rd(A_ST, 32'h04, "irq_idle_high", 1'b0, 1'b1, 1'b1, 1'b1);
        wr(A_TX, 32'h3C); e = cyc;
        exp_frame(8'h3C, e + 1);
        rd(A_ST, 32'h10, "irq_at_push", 1'b0, 1'b1, 1'b1, 1'b1);
        rd(A_ST, 32'h05, "irq_low_busy", 1'b0, 1'b1, 1'b1, 1'b0);
        wait_cyc(e + 41);
        rd(A_ST, 32'h04, "irq_low_at_stop_end", 1'b0, 1'b1, 1'b1, 1'b0);
        rd(A_ST, 32'h04, "irq_rises", 1'b0, 1'b1, 1'b1, 1'b1);
        wr(A_IRQ, 32'h0);
        rd(A_ST, 32'h04, "irq_still_high", 1'b0, 1'b1, 1'b1, 1'b1);
        rd(A_ST, 32'h04, "irq_dropped", 1'b0, 1'b1, 1'b1, 1'b0);
`endif

        repeat (5) @(posedge clk);
        chk("frames_pending", 32'(frame_q.size()), 32'd0);
        chk("reads_pending", 32'(rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
